hwpe_ctrl_jobqueue: RTL

Generalised offload controller for HWPE accelerators. It accepts jobs from N_CORES cores through the peripheral config port, queues them in a circular context queue of arbitrary depth N_CONTEXT, and sequences them to the datapath. Each job is tagged with an 8-bit wrapping job ID. Acquire locks have a timeout, and the done event is routed only to the core that triggered the job. It sits between the peripheral interconnect and the register file and datapath of an accelerator.

---
 rtl/hwpe_ctrl_jobqueue_if.sv | 28 ++
 rtl/hwpe_ctrl_jobqueue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_jobqueue_if.sv
// Peripheral config port of the HWPE job queue controller.
// master: the interconnect side driving requests (req/add/wen/be/data/id).
// slave:  the controller side returning grant and the registered response
//         (gnt/r_data/r_valid/r_id).
interface hwpe_ctrl_jobqueue_if #(
  parameter int unsigned ID_WIDTH = 16
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;     // 1 = read, 0 = write
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/hwpe_ctrl_jobqueue.sv
// HWPE offload controller with a circular job queue.
// Cores acquire a lock (ACQUIRE read returns the job ID), then commit the job
// with a TRIGGER write. Committed jobs are sequenced to the datapath one at a
// time; the done event is routed back to the core that triggered the job.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cfg           : peripheral config port (slave modport)
//   wr_ctx_o      : slot currently being programmed
//   run_ctx_o     : slot currently executing
//   start_o       : one-cycle datapath start pulse
//   busy_o        : datapath executing a job
//   done_i        : datapath done (counted only while running)
//   evt_o         : per-core one-cycle done event
//   clear_o       : two-cycle soft clear to datapath and register file
module hwpe_ctrl_jobqueue #(
  parameter int unsigned N_CORES      = 4,
  parameter int unsigned N_CONTEXT    = 2,
  parameter int unsigned ID_WIDTH     = 16,
  parameter int unsigned LOCK_TIMEOUT = 256,
  localparam int unsigned CtxW        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  hwpe_ctrl_jobqueue_if.slave        cfg,
  output logic [CtxW-1:0]            wr_ctx_o,
  output logic [CtxW-1:0]            run_ctx_o,
  output logic                       start_o,
  output logic                       busy_o,
  input  logic                       done_i,
  output logic [N_CORES-1:0]         evt_o,
  output logic                       clear_o
);

  localparam int unsigned OwnW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned PendW = $clog2(N_CONTEXT + 1);
  localparam int unsigned TmrW  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [3:0] RegTrigger   = 4'd0;
  localparam logic [3:0] RegAcquire   = 4'd1;
  localparam logic [3:0] RegFinished  = 4'd2;
  localparam logic [3:0] RegStatus    = 4'd3;
  localparam logic [3:0] RegSoftClear = 4'd4;

  typedef enum logic [1:0] {StIdle, StPrep, StRun} state_e;

  state_e              state_q, state_d;
  logic [PendW-1:0]    pending_q, pending_d;
  logic                locked_q, locked_d;
  logic [OwnW-1:0]     owner_q, owner_d;
  logic [7:0]          next_id_q, next_id_d;
  logic [31:0]         finished_q, finished_d;
  logic [CtxW-1:0]     wr_ctx_q, wr_ctx_d;
  logic [CtxW-1:0]     run_ctx_q, run_ctx_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [1:0]          clr_cnt_q, clr_cnt_d;
  logic                start_q, start_d;
  logic [N_CORES-1:0]  evt_q, evt_d;
  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_data_q, r_data_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [OwnW-1:0]     slot_owner_q [N_CONTEXT];
  logic [OwnW-1:0]     slot_owner_d [N_CONTEXT];
  logic [7:0]          slot_id_q    [N_CONTEXT];
  logic [7:0]          slot_id_d    [N_CONTEXT];

  logic [3:0]          reg_idx;
  logic                is_rd, is_wr;
  logic                clear_act;
  logic [OwnW-1:0]     req_owner;
  logic                acq_ok, trig_ok, clr_start, done_ok;
  logic [7:0]          run_id;
  logic [31:0]         status;
  logic [31:0]         rdata;

  // Write data, byte enables and non-index address bits carry no information.
  logic unused_cfg;
  assign unused_cfg = ^{cfg.be, cfg.data, cfg.add[31:6], cfg.add[1:0]};

  function automatic logic [CtxW-1:0] ctx_inc(input logic [CtxW-1:0] p);
    return (p == CtxW'(N_CONTEXT - 1)) ? '0 : p + CtxW'(1);
  endfunction

  // Requester is the lowest set bit of the one-hot core field; none set -> 0.
  always_comb begin
    req_owner = '0;
    for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
      if (cfg.id[i]) req_owner = OwnW'(i);
    end
  end

  assign reg_idx   = cfg.add[5:2];
  assign is_rd     = cfg.req & cfg.wen;
  assign is_wr     = cfg.req & ~cfg.wen;
  assign clear_act = (clr_cnt_q != 2'd0);

  // No lock is handed out during clear: the clear would wipe it immediately.
  assign acq_ok    = is_rd && (reg_idx == RegAcquire) && !locked_q &&
                     (pending_q < PendW'(N_CONTEXT)) && !clear_act;
  assign trig_ok   = is_wr && (reg_idx == RegTrigger) && locked_q &&
                     (req_owner == owner_q) && !clear_act;
  assign clr_start = is_wr && (reg_idx == RegSoftClear) && !clear_act;
  assign done_ok   = done_i && (state_q == StRun) && !clear_act;

  assign busy_o    = (state_q != StIdle) && !clear_act;
  assign run_id    = busy_o ? slot_id_q[run_ctx_q] : 8'd0;
  assign status    = {8'd0, run_id, 8'(pending_q), 6'd0, locked_q, busy_o};

  always_comb begin
    rdata = 32'd0;
    if (is_rd) begin
      case (reg_idx)
        RegAcquire:  rdata = acq_ok ? {24'd0, next_id_q} : 32'hFFFF_FFFF;
        RegFinished: rdata = finished_q;
        RegStatus:   rdata = status;
        default:     rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    next_id_d    = next_id_q;
    finished_d   = finished_q;
    wr_ctx_d     = wr_ctx_q;
    run_ctx_d    = run_ctx_q;
    tmr_d        = tmr_q;
    clr_cnt_d    = clr_cnt_q;
    start_d      = 1'b0;
    evt_d        = '0;
    slot_owner_d = slot_owner_q;
    slot_id_d    = slot_id_q;
    r_valid_d    = cfg.req;
    r_data_d     = r_data_q;
    r_id_d       = r_id_q;

    if (cfg.req) begin
      r_data_d = rdata;
      r_id_d   = cfg.id;
    end

    // Lock timer: an unused lock expires without consuming the job ID.
    if (locked_q && (LOCK_TIMEOUT != 0)) begin
      tmr_d = tmr_q + TmrW'(1);
      if (tmr_d == TmrW'(LOCK_TIMEOUT)) locked_d = 1'b0;
    end

    if (acq_ok) begin
      locked_d = 1'b1;
      owner_d  = req_owner;
      tmr_d    = '0;
    end

    if (trig_ok) begin
      slot_owner_d[wr_ctx_q] = owner_q;
      slot_id_d[wr_ctx_q]    = next_id_q;
      wr_ctx_d               = ctx_inc(wr_ctx_q);
      next_id_d              = next_id_q + 8'd1;
      locked_d               = 1'b0;
    end

    // A commit and a completion in the same cycle cancel out.
    if (trig_ok && !done_ok) begin
      pending_d = pending_q + PendW'(1);
    end else if (!trig_ok && done_ok) begin
      pending_d = pending_q - PendW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) state_d = StPrep;
      end
      StPrep: begin
        state_d = StRun;
        start_d = 1'b1;
      end
      StRun: begin
        if (done_ok) begin
          run_ctx_d = ctx_inc(run_ctx_q);
          if (finished_q != 32'hFFFF_FFFF) finished_d = finished_q + 32'd1;
          evt_d[slot_owner_q[run_ctx_q]] = 1'b1;
          state_d = (pending_d != '0) ? StPrep : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear_act) begin
      clr_cnt_d  = clr_cnt_q - 2'd1;
      state_d    = StIdle;
      pending_d  = '0;
      locked_d   = 1'b0;
      wr_ctx_d   = '0;
      run_ctx_d  = '0;
      next_id_d  = 8'd0;
      finished_d = 32'd0;
      tmr_d      = '0;
      start_d    = 1'b0;
      evt_d      = '0;
    end else if (clr_start) begin
      clr_cnt_d = 2'd2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      locked_q     <= 1'b0;
      owner_q      <= '0;
      next_id_q    <= 8'd0;
      finished_q   <= 32'd0;
      wr_ctx_q     <= '0;
      run_ctx_q    <= '0;
      tmr_q        <= '0;
      clr_cnt_q    <= 2'd0;
      start_q      <= 1'b0;
      evt_q        <= '0;
      r_valid_q    <= 1'b0;
      r_data_q     <= 32'd0;
      r_id_q       <= '0;
      slot_owner_q <= '{default: '0};
      slot_id_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      next_id_q    <= next_id_d;
      finished_q   <= finished_d;
      wr_ctx_q     <= wr_ctx_d;
      run_ctx_q    <= run_ctx_d;
      tmr_q        <= tmr_d;
      clr_cnt_q    <= clr_cnt_d;
      start_q      <= start_d;
      evt_q        <= evt_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_id_q       <= r_id_d;
      slot_owner_q <= slot_owner_d;
      slot_id_q    <= slot_id_d;
    end
  end

  assign cfg.gnt     = 1'b1;
  assign cfg.r_valid = r_valid_q;
  assign cfg.r_data  = r_data_q;
  assign cfg.r_id    = r_id_q;

  assign wr_ctx_o  = wr_ctx_q;
  assign run_ctx_o = run_ctx_q;
  assign start_o   = start_q && !clear_act;
  assign evt_o     = clear_act ? '0 : evt_q;
  assign clear_o   = clear_act;

endmodule
